// File: rtl/obstacle_pkg.sv
// Shared types, screen constants and the box-overlap helper for the obstacle engine.
package obstacle_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DONE
    } slot_state_t;

    // Block spans columns [pos-bw, pos). The left-edge test is rearranged to
    // px+pw+bw > pos so that pos < bw cannot wrap below zero.
    function automatic logic overlap(
        input logic [10:0] pos,
        input logic [10:0] bw,
        input logic [10:0] by,
        input logic [10:0] bh,
        input logic [10:0] px,
        input logic [10:0] pw,
        input logic [10:0] py,
        input logic [10:0] ph
    );
        overlap = (px < pos) && ((px + pw + bw) > pos) &&
                  (py < (by + bh)) && ((py + ph) > by);
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: IDLE/MOVING/DONE FSM, position, pass count, step and overlap flag.
// Optional OBSTACLE_SPEED_RAMP_EN: step grows by one on every wrap up to MAX_STEP.
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int unsigned BLOCK_W   = 32,
    parameter int unsigned BLOCK_H   = 32,
    parameter int unsigned BLOCK_Y   = 400,
    parameter int unsigned PLAYER_W  = 24,
    parameter int unsigned PLAYER_H  = 24,
    parameter int unsigned PASSES    = 3,
    parameter int unsigned BASE_STEP = 2,
    parameter int unsigned MAX_STEP  = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_tick,
    input  logic        i_ready,
    input  logic [9:0]  i_player_x,
    input  logic [9:0]  i_player_y,
    output logic [10:0] o_pos,
    output logic        o_vis,
    output logic        o_done,
    output logic        o_overlap
);

    localparam logic [10:0] START  = 11'(SCREEN_W + BLOCK_W);
    localparam int unsigned PASS_W = $clog2(PASSES + 1);
    // Base step never exceeds the ceiling, even with odd parameter choices.
    localparam logic [10:0] STEP0  = 11'((BASE_STEP < MAX_STEP) ? BASE_STEP : MAX_STEP);

    slot_state_t       r_state, w_state_next;
    logic [10:0]       r_pos, w_pos_next;
    logic [PASS_W-1:0] r_pass, w_pass_next;
    logic [10:0]       w_step;
    logic              w_wrap;

    // Next-state: dropping ready forces IDLE and outranks any frame tick.
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_pass_next  = r_pass;
        w_wrap       = 1'b0;
        if (!i_ready) begin
            w_state_next = IDLE;
            w_pos_next   = START;
            w_pass_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = MOVING;
                    w_pos_next   = START;
                    w_pass_next  = '0;
                end
                MOVING: begin
                    if (i_frame_tick) begin
                        if (r_pos > w_step) begin
                            w_pos_next = r_pos - w_step;
                        end else begin
                            w_pos_next  = START;
                            w_pass_next = r_pass + 1'b1;
                            w_wrap      = 1'b1;
                            if (r_pass == PASS_W'(PASSES - 1)) begin
                                w_state_next = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    w_pos_next = START;
                end
                default: begin
                    w_state_next = IDLE;
                    w_pos_next   = START;
                    w_pass_next  = '0;
                end
            endcase
        end
    end

    // State, position and pass registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pos   <= START;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_pass  <= w_pass_next;
        end
    end

`ifdef OBSTACLE_SPEED_RAMP_EN
    logic [10:0] r_step, w_step_next;

    // Step ramps by one per wrap up to the ceiling and returns to base when idle.
    always_comb begin
        w_step_next = r_step;
        if (!i_ready || r_state == IDLE) begin
            w_step_next = STEP0;
        end else if (w_wrap) begin
            w_step_next = (r_step >= 11'(MAX_STEP)) ? 11'(MAX_STEP) : r_step + 11'd1;
        end
    end

    // Step register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_step <= STEP0;
        end else begin
            r_step <= w_step_next;
        end
    end

    assign w_step = r_step;
`else
    assign w_step = STEP0;
`endif

    assign o_pos     = r_pos;
    assign o_vis     = (r_state == MOVING);
    assign o_done    = (r_state == DONE);
    assign o_overlap = (r_state == MOVING) &&
                       overlap(r_pos, 11'(BLOCK_W), 11'(BLOCK_Y), 11'(BLOCK_H),
                               {1'b0, i_player_x}, 11'(PLAYER_W),
                               {1'b0, i_player_y}, 11'(PLAYER_H));

endmodule

// File: rtl/obstacle_bank.sv
// Obstacle engine top: N_SLOTS obstacle slots, collision edge detectors, off-screen check.
// Optional OBSTACLE_SPEED_RAMP_EN enables per-wrap speed ramping inside each slot.
module obstacle_bank
    import obstacle_pkg::*;
#(
    parameter int unsigned N_SLOTS   = 10,
    parameter int unsigned BLOCK_W   = 32,
    parameter int unsigned BLOCK_H   = 32,
    parameter int unsigned BLOCK_Y   = 400,
    parameter int unsigned PLAYER_W  = 24,
    parameter int unsigned PLAYER_H  = 24,
    parameter int unsigned PASSES    = 3,
    parameter int unsigned BASE_STEP = 2,
    parameter int unsigned MAX_STEP  = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_tick,
    input  logic [0:N_SLOTS-1]        block_ready,
    input  logic [9:0]                player_x,
    input  logic [9:0]                player_y,
    output logic [0:1]                Collision,
    output logic [0:N_SLOTS-1]        end_level,
    output logic [N_SLOTS-1:0][10:0]  block_x,
    output logic [0:N_SLOTS-1]        block_vis
);

    logic [N_SLOTS-1:0] w_overlap;
    logic               w_any_overlap;
    logic               w_off_screen;
    logic               r_ovl_prev, r_off_prev;
    logic               r_coll_ovl, r_coll_off;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        obstacle_slot #(
            .BLOCK_W   (BLOCK_W),
            .BLOCK_H   (BLOCK_H),
            .BLOCK_Y   (BLOCK_Y),
            .PLAYER_W  (PLAYER_W),
            .PLAYER_H  (PLAYER_H),
            .PASSES    (PASSES),
            .BASE_STEP (BASE_STEP),
            .MAX_STEP  (MAX_STEP)
        ) u_slot (
            .i_clk        (Clk),
            .i_reset      (Reset),
            .i_frame_tick (frame_tick),
            .i_ready      (block_ready[g]),
            .i_player_x   (player_x),
            .i_player_y   (player_y),
            .o_pos        (block_x[g]),
            .o_vis        (block_vis[g]),
            .o_done       (end_level[g]),
            .o_overlap    (w_overlap[g])
        );
    end

    assign w_any_overlap = |w_overlap;
    assign w_off_screen  = ({1'b0, player_y} + 11'(PLAYER_H)) > 11'(SCREEN_H);

    // Rising-edge detectors: sustained conditions report a single pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovl_prev <= 1'b0;
            r_off_prev <= 1'b0;
            r_coll_ovl <= 1'b0;
            r_coll_off <= 1'b0;
        end else begin
            r_ovl_prev <= w_any_overlap;
            r_off_prev <= w_off_screen;
            r_coll_ovl <= w_any_overlap & ~r_ovl_prev;
            r_coll_off <= w_off_screen & ~r_off_prev;
        end
    end

    assign Collision[0] = r_coll_ovl;
    assign Collision[1] = r_coll_off;

endmodule
